// File: rtl/mult_share_ctrl.sv
// Round-robin controller that time-shares one 131x128 multiplier accelerator
// among NUM_REQ requesters and returns each tagged product, with a wait watchdog.
module mult_share_ctrl #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*131-1:0] req_a,
    input  logic [NUM_REQ*128-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [258:0]           resp_p,
    output logic                   resp_err,
    output logic                   acc_start,
    output logic [130:0]           acc_a,
    output logic [127:0]           acc_b,
    input  logic [258:0]           acc_p,
    input  logic                   acc_ready,
    output logic                   busy,
    output logic [1:0]             dbg_state
);
    localparam int AW    = 131;
    localparam int BW    = 128;
    localparam int PW    = 259;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; ready never depends on the transfer itself, and a response is
    // held unchanged while resp_valid is high and resp_ready is low.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [PW-1:0]    resp_p_q, resp_p_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic             acc_start_q, acc_start_d;
    logic [AW-1:0]    acc_a_q, acc_a_d;
    logic [BW-1:0]    acc_b_q, acc_b_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [AW-1:0]       sel_a;
    logic [BW-1:0]       sel_b;
    int                  scan_idx;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        grant_oh    = '0;
        sel_a       = '0;
        sel_b       = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found        = 1'b1;
                grant              = ID_W'(scan_idx);
                grant_oh[scan_idx] = 1'b1;
                sel_a              = req_a[scan_idx*AW +: AW];
                sel_b              = req_b[scan_idx*BW +: BW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        resp_id_d    = resp_id_q;
        resp_p_d     = resp_p_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        acc_start_d  = 1'b0;
        acc_a_d      = acc_a_q;
        acc_b_d      = acc_b_q;
        wait_cnt_d   = wait_cnt_q;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready   = grant_oh;
                    acc_a_d     = sel_a;
                    acc_b_d     = sel_b;
                    resp_id_d   = grant;
                    acc_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A done level seen in the first WAIT cycle may predate our start.
                if (wait_cnt_q != '0 && acc_ready) begin
                    resp_p_d     = acc_p;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    resp_p_d     = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    rr_ptr_d     = (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            resp_id_q    <= '0;
            resp_p_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            acc_start_q  <= 1'b0;
            acc_a_q      <= '0;
            acc_b_q      <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            resp_id_q    <= resp_id_d;
            resp_p_q     <= resp_p_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            acc_start_q  <= acc_start_d;
            acc_a_q      <= acc_a_d;
            acc_b_q      <= acc_b_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_p     = resp_p_q;
    assign resp_err   = resp_err_q;
    assign acc_start  = acc_start_q;
    assign acc_a      = acc_a_q;
    assign acc_b      = acc_b_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: transaction-level reference model, behavioural
// accelerator with selectable latency, directed scenarios then random traffic.
module tb_mult_share_ctrl;
    localparam int NUM_REQ     = 4;
    localparam int ID_W        = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int AW          = 131;
    localparam int BW          = 128;
    localparam int PW          = 259;
    localparam int EW          = ID_W + 1 + PW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req_valid, req_ready;
    logic [NUM_REQ*AW-1:0] req_a;
    logic [NUM_REQ*BW-1:0] req_b;
    logic                  resp_valid, resp_ready, resp_err;
    logic [ID_W-1:0]       resp_id;
    logic [PW-1:0]         resp_p;
    logic                  acc_start, acc_ready, busy;
    logic [AW-1:0]         acc_a;
    logic [BW-1:0]         acc_b;
    logic [PW-1:0]         acc_p;
    logic [1:0]            dbg_state;

    mult_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_p(resp_p), .resp_err(resp_err),
        .acc_start(acc_start), .acc_a(acc_a), .acc_b(acc_b), .acc_p(acc_p),
        .acc_ready(acc_ready), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [PW-1:0] x, y;
        x = a;
        y = b;
        return x * y;
    endfunction

    function automatic logic [AW-1:0] rand_a();
        logic [159:0] w;
        for (int k = 0; k < 5; k++) w[k*32 +: 32] = $urandom;
        return w[AW-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_b();
        logic [127:0] w;
        for (int k = 0; k < 4; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // ---------------- reference model state ----------------
    int               cyc = 0;
    bit               mon_en = 1'b0;
    bit               m_busy = 1'b0;
    int               m_rr = 0;
    int               m_due = 0;
    int               m_start_cyc = -10;
    logic [AW-1:0]    m_a;
    logic [BW-1:0]    m_b;
    logic [EW-1:0]    exp_q[$];
    int               grant_log[$];
    logic [NUM_REQ-1:0] hs_mask = '0;

    // stimulus knobs
    int  fixed_lat = 12;
    bit  rand_lat  = 1'b0;
    bit  rand_drop = 1'b0;
    bit  rand_rr   = 1'b0;
    int  cur_lat   = 12;
    bit  cur_stale = 1'b0;
    logic [AW-1:0] src_a [NUM_REQ][$];
    logic [BW-1:0] src_b [NUM_REQ][$];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural accelerator: done level rises cur_lat edges after the start
    // edge; lat >= TIMEOUT_CYC means it never answers. Stale mode clears the
    // previous done level one edge late.
    int            acc_cnt = 0;
    bit            acc_clr_pend = 1'b0;
    logic [PW-1:0] acc_prod = '0;
    always @(posedge clk) begin
        if (reset) begin
            acc_ready    <= 1'b0;
            acc_p        <= '0;
            acc_cnt      <= 0;
            acc_clr_pend <= 1'b0;
        end else if (acc_start) begin
            if (cur_stale) acc_clr_pend <= 1'b1;
            else           acc_ready    <= 1'b0;
            acc_cnt  <= (cur_lat >= TIMEOUT_CYC) ? 0 : cur_lat;
            acc_prod <= ref_mul(acc_a, acc_b);
        end else begin
            if (acc_clr_pend) begin
                acc_ready    <= 1'b0;
                acc_clr_pend <= 1'b0;
            end
            if (acc_cnt > 0) begin
                acc_cnt <= acc_cnt - 1;
                if (acc_cnt == 1) begin
                    acc_ready <= 1'b1;
                    acc_p     <= acc_prod;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [NUM_REQ-1:0] exp_rdy, dut_hs;
    logic [EW-1:0]      e;
    logic [PW-1:0]      ep;
    bit                 ev, eerr, logged;
    int                 g, lat, mi;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            exp_rdy = '0;
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    mi = (m_rr + k) % NUM_REQ;
                    if (exp_rdy == '0 && req_valid[mi]) exp_rdy[mi] = 1'b1;
                end
            end
            check("req_ready", PW'(req_ready), PW'(exp_rdy));
            check("busy", PW'(busy), PW'(m_busy));
            check("acc_start", PW'(acc_start), PW'(m_busy && cyc == m_start_cyc));
            if (m_busy) begin
                check("acc_a", PW'(acc_a), PW'(m_a));
                check("acc_b", PW'(acc_b), PW'(m_b));
            end
            ev = (exp_q.size() != 0) && (cyc >= m_due);
            check("resp_valid", PW'(resp_valid), PW'(ev));
            if (ev) begin
                e = exp_q[0];
                check("resp_id", PW'(resp_id), PW'(e[EW-1 -: ID_W]));
                check("resp_err", PW'(resp_err), PW'(e[PW]));
                check("resp_p", resp_p, e[PW-1:0]);
            end
            dut_hs = req_valid & req_ready;
            logged = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (dut_hs[k] && !logged) begin
                    grant_log.push_back(k);
                    logged = 1'b1;
                end
            end
            hs_mask = exp_rdy;
            if (exp_rdy != '0) begin
                g = 0;
                for (int k = 0; k < NUM_REQ; k++) if (exp_rdy[k]) g = k;
                m_a = req_a[g*AW +: AW];
                m_b = req_b[g*BW +: BW];
                if (rand_lat) begin
                    lat       = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(2, 30);
                    cur_stale = bit'($urandom_range(0, 1));
                end else begin
                    lat       = fixed_lat;
                    cur_stale = 1'b0;
                end
                cur_lat = lat;
                eerr    = (lat >= TIMEOUT_CYC);
                ep      = eerr ? '0 : ref_mul(m_a, m_b);
                exp_q.push_back({ID_W'(g), eerr, ep});
                m_due       = cyc + (eerr ? TIMEOUT_CYC + 2 : lat + 3);
                m_start_cyc = cyc + 1;
                m_busy      = 1'b1;
            end else if (ev && resp_ready) begin
                m_rr = (int'(e[EW-1 -: ID_W]) + 1) % NUM_REQ;
                void'(exp_q.pop_front());
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        src_a[i].push_back(a);
        src_b[i].push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin
                req_valid[i] = 1'b0;
            end else if (req_valid[i] && rand_drop && $urandom_range(0, 7) == 0) begin
                src_a[i].push_front(req_a[i*AW +: AW]);
                src_b[i].push_front(req_b[i*BW +: BW]);
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && src_a[i].size() > 0 && (!rand_drop || $urandom_range(0, 3) != 0)) begin
                req_a[i*AW +: AW] = src_a[i].pop_front();
                req_b[i*BW +: BW] = src_b[i].pop_front();
                req_valid[i] = 1'b1;
            end
        end
        if (rand_rr) resp_ready = ($urandom_range(0, 2) != 0);
        hs_mask = '0;
    endtask

    task automatic model_clear();
        m_busy  = 1'b0;
        m_rr    = 0;
        hs_mask = '0;
        exp_q.delete();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_a[i].delete();
            src_b[i].delete();
        end
        model_clear();
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit idle_seen;
        idle_seen = 1'b0;
        for (int n = 0; n < budget && !idle_seen; n++) begin
            step();
            idle_seen = (exp_q.size() == 0) && !m_busy && (req_valid == '0);
            for (int i = 0; i < NUM_REQ; i++) if (src_a[i].size() != 0) idle_seen = 1'b0;
        end
        check("drain_done", PW'(idle_seen), PW'(1'b1));
    endtask

    task automatic wait_busy(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            seen = m_busy;
        end
        check("wait_busy", PW'(seen), PW'(1'b1));
    endtask

    task automatic wait_resp(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            step();
            seen = resp_valid;
        end
        check("wait_resp", PW'(seen), PW'(1'b1));
    endtask

    // ---------------- main sequence ----------------
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", PW'(req_ready), '0);
        check("rst_resp_valid", PW'(resp_valid), '0);
        check("rst_resp_err", PW'(resp_err), '0);
        check("rst_resp_id", PW'(resp_id), '0);
        check("rst_resp_p", resp_p, '0);
        check("rst_acc_start", PW'(acc_start), '0);
        check("rst_acc_a", PW'(acc_a), '0);
        check("rst_acc_b", PW'(acc_b), '0);
        check("rst_busy", PW'(busy), '0);
        mon_en = 1'b1;

        // single request, resp_ready already high before RESP
        resp_ready = 1'b1;
        push(2, 131'd3, 128'd5);
        drain(200);

        // all four continuously valid from a fresh reset: grants 0,1,2,3,0
        do_reset(2);
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) push(i, AW'(i + 1), 128'd7);
        push(0, 131'd1, 128'd7);
        drain(400);
        check("grant_count", PW'(grant_log.size()), PW'(5));
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("grant_order", PW'(grant_log[k]), PW'(exp_order[k]));

        // backpressure in RESP with competing requesters
        resp_ready = 1'b0;
        push(3, rand_a(), rand_b());
        wait_resp(100);
        push(0, rand_a(), rand_b());
        push(1, rand_a(), rand_b());
        repeat (20) step();
        resp_ready = 1'b1;
        drain(400);

        // accelerator never answers: watchdog response
        fixed_lat = 100;
        push(0, 131'd9, 128'd9);
        drain(200);
        fixed_lat = 12;

        // all-ones operands through the full width
        push(1, '1, '1);
        drain(200);

        // reset during WAIT, then contention between 1 and 3 must grant 1
        push(2, rand_a(), rand_b());
        wait_busy(50);
        repeat (5) step();
        do_reset(1);
        @(negedge clk);
        check("midrst_busy", PW'(busy), '0);
        check("midrst_acc_start", PW'(acc_start), '0);
        check("midrst_resp_valid", PW'(resp_valid), '0);
        check("midrst_acc_a", PW'(acc_a), '0);
        grant_log.delete();
        push(1, rand_a(), rand_b());
        push(3, rand_a(), rand_b());
        drain(400);
        check("midrst_first_grant", PW'(grant_log.size() > 0 ? grant_log[0] : -1), PW'(1));

        // randomized traffic
        rand_lat  = 1'b1;
        rand_drop = 1'b1;
        rand_rr   = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) push($urandom_range(0, NUM_REQ - 1), '1, rand_b());
            else push($urandom_range(0, NUM_REQ - 1), rand_a(), rand_b());
        end
        drain(20000);
        rand_rr    = 1'b0;
        resp_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: observed no end of test, expected finish before %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
